regfile_write_arbiter: RTL
==========================

Name: regfile_write_arbiter

Overview:
- Shares the single write port of the team's register file (`bits` wide, 2**`width` entries, write-enable/address/data write port) among `NREQ` requesters.
- Requesters use a valid/ready handshake. A round-robin arbiter grants one write per cycle.
- Also contains a clear sequencer that zeros every entry, one per cycle, on command.
- Sits directly in front of the register file write port. The read port is not touched.

Parameters:
- bits, 8, data width of each register entry
- width, 4, address width; depth = 2**width entries
- NREQ, 4, number of write requesters (>= 2)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- req_valid  input  NREQ  per-requester write request
- req_addr  input  NREQ*width  packed addresses; requester i at [i*width +: width]
- req_data  input  NREQ*bits  packed data; requester i at [i*bits +: bits]
- req_ready  output  NREQ  per-requester accept, one-hot or zero
- clear_start  input  1  single-cycle command to zero the whole file
- clear_busy  output  1  high while clear sequence is in progress
- clear_done  output  1  one-cycle pulse in the final clear write cycle
- rf_w_en  output  1  to register file write enable
- rf_w_addr  output  width  to register file write address
- rf_w_data  output  bits  to register file write data
- grant_id  output  clog2(NREQ)  source index of the write currently on rf_w_*; 0 during clear

Behaviour:
- Clock and reset: one clock `clk`. `rst` is synchronous, active-high.
- Reset values:
  - state = RUN, round-robin pointer = 0, clear counter = 0.
  - rf_w_en = 0, rf_w_addr = 0, rf_w_data = 0, grant_id = 0.
  - clear_busy = 0, clear_done = 0.
  - Reset has priority over every other event, including mid-clear: the sequence aborts and the remaining entries are left unwritten.
- States: RUN and CLEAR. clear_busy = (state == CLEAR).
- RUN arbitration (combinational):
  - Scan ptr, ptr+1, ..., ptr+NREQ-1 (mod NREQ). The first index with req_valid high is the winner.
  - req_ready[winner] = 1, all other ready bits = 0.
  - All ready bits are 0 if no valid request, if clear_start = 1, or if state = CLEAR.
  - req_ready must not depend on req_addr or req_data.
- Accept: req_valid[i] & req_ready[i] at edge E.
  - On the next cycle (registered, latency 1): rf_w_en = 1, rf_w_addr = req_addr[i], rf_w_data = req_data[i], grant_id = i.
  - ptr <= (i+1) mod NREQ.
  - If nothing is accepted, ptr is unchanged and rf_w_en = 0 on the next cycle.
- Throughput: one accepted write per cycle, sustained back-to-back.
- A requester holding valid without a grant keeps its request. The arbiter never drops or reorders a request from a single requester.
- Clear sequence:
  - clear_start = 1 in RUN during cycle T: state -> CLEAR at the end of T. Any same-cycle request is not accepted.
  - Cycles T+1 .. T+2**width: rf_w_en = 1, rf_w_addr = 0, 1, ..., 2**width-1 in order, rf_w_data = 0, grant_id = 0.
  - clear_done = 1 only in cycle T+2**width.
  - State returns to RUN at the end of that cycle. The first grant can occur in cycle T+2**width+1, with its write in T+2**width+2.
- clear_start during CLEAR: ignored. No restart, no extension.
- clear_start and requests arriving in the same RUN cycle: clear wins, and requests wait with ptr unchanged.
- Clear counter: `width`+1 bits or a compare on the last address. It must not wrap before the last entry is written.
- Arithmetic:
  - ptr update is modulo NREQ and must be correct for non-power-of-2 NREQ.
  - grant_id width is clog2(NREQ), minimum 1.

Test Plan:
- Reset: assert rst 2 cycles with all req_valid = 1 and clear_start = 1 -> all outputs 0 during reset and in the first cycle after it. First grant goes to requester 0.
- Single requester: req_valid = 4'b0100, addr 5, data 8'hA5 -> req_ready = 4'b0100 the same cycle. Next cycle rf_w_en = 1, rf_w_addr = 5, rf_w_data = 8'hA5, grant_id = 2.
- Round-robin fairness: all 4 valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3, one rf write per cycle. Then drop requester 1 -> order skips 1 (e.g. 2,3,0,2,...).
- Clear: pulse clear_start at cycle T (width = 4) -> rf_w_addr 0..15 with data 0 on cycles T+1..T+16. clear_busy high for those 16 cycles, clear_done high only at T+16. A second clear_start at T+5 has no effect.
- Clear vs request: clear_start and req_valid[3] both high in the same cycle -> no ready that cycle and none during CLEAR. Requester 3 is granted at T+17, and its write appears at T+18.
- Reset mid-clear: rst at T+6 -> next cycle rf_w_en = 0, clear_busy = 0, state RUN. Entries 6..15 are never written (check with a register file model).

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ requesters,
// plus a clear sequencer that zeros every entry, one entry per cycle.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   RUN   | arbitrate requesters, at most one registered write per cycle
//   CLEAR | write zero to entries 0 .. 2**width-1 in order, no grants
module regfile_write_arbiter #(
  parameter  int bits  = 8,
  parameter  int width = 4,
  parameter  int NREQ  = 4,
  localparam int IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*width-1:0]   req_addr,
  input  logic [NREQ*bits-1:0]    req_data,
  output logic [NREQ-1:0]         req_ready,
  input  logic                    clear_start,
  output logic                    clear_busy,
  output logic                    clear_done,
  output logic                    rf_w_en,
  output logic [width-1:0]        rf_w_addr,
  output logic [bits-1:0]         rf_w_data,
  output logic [IDW-1:0]          grant_id
);

  localparam int               DEPTH    = 2 ** width;
  localparam logic [width-1:0] CLR_LAST = width'(DEPTH - 1);
  localparam logic [IDW:0]     NREQ_W   = (IDW + 1)'(NREQ);
  localparam logic [IDW-1:0]   LAST_ID  = IDW'(NREQ - 1);

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [width-1:0] clr_left;
  logic             grant_any;
  logic [IDW-1:0]   grant_idx;
  logic [IDW:0]     scan_sum;
  logic [IDW-1:0]   scan_idx;

  // First valid requester at or after ptr, wrapping modulo NREQ.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, ptr} + (IDW + 1)'(k);
      if (scan_sum >= NREQ_W) begin
        scan_sum = scan_sum - NREQ_W;
      end
      scan_idx = scan_sum[IDW-1:0];
      if (!grant_any && req_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (!rst && (state == RUN) && !clear_start && grant_any) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign clear_busy = (state == CLEAR);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      ptr        <= '0;
      clr_left   <= '0;
      rf_w_en    <= 1'b0;
      rf_w_addr  <= '0;
      rf_w_data  <= '0;
      grant_id   <= '0;
      clear_done <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          clear_done <= 1'b0;
          if (clear_start) begin
            state      <= CLEAR;
            clr_left   <= CLR_LAST;
            rf_w_en    <= 1'b1;
            rf_w_addr  <= '0;
            rf_w_data  <= '0;
            grant_id   <= '0;
            clear_done <= (CLR_LAST == '0);
          end else if (grant_any) begin
            rf_w_en   <= 1'b1;
            rf_w_addr <= req_addr[grant_idx*width +: width];
            rf_w_data <= req_data[grant_idx*bits +: bits];
            grant_id  <= grant_idx;
            ptr       <= (grant_idx == LAST_ID) ? '0 : grant_idx + 1'b1;
          end else begin
            rf_w_en <= 1'b0;
          end
        end
        CLEAR: begin
          // clr_left counts the clear writes still to come after the current one.
          if (clr_left == '0) begin
            state      <= RUN;
            rf_w_en    <= 1'b0;
            clear_done <= 1'b0;
          end else begin
            rf_w_addr  <= rf_w_addr + 1'b1;
            clr_left   <= clr_left - 1'b1;
            clear_done <= (clr_left == width'(1));
          end
        end
        default: begin
          state <= RUN;
        end
      endcase
    end
  end

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  a_done_in_busy: assert property (@(posedge clk) disable iff (rst) clear_done |-> clear_busy);

endmodule
